// File: rtl/spi_rx_deserializer_pkg.sv
// Shared constants and helpers for the SPI master receive path.
package spi_pkg;

  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PUSH  = 2'd2
  } state_e;

  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned PTR_W_DEF = 4;

  localparam int unsigned RXFO_BIT = 0;
  localparam int unsigned RXFF_BIT = 1;
  localparam int unsigned RXFE_BIT = 2;

  // Keeps the low word_size+1 bits; word_size=31 yields all ones.
  function automatic logic [31:0] word_mask(input logic [4:0] ws);
    logic [32:0] m;
    m = (33'd1 << ({1'b0, ws} + 6'd1)) - 33'd1;
    return m[31:0];
  endfunction

endpackage

// File: rtl/spi_rx_deserializer_if.sv
// Avalon-side register view of the receive path: DATA read/pop, status flags, debug pointers.
interface spi_rx_deserializer_if #(
  parameter int unsigned PTR_W = 4
);
  logic             pop;
  logic             clear_ov;
  logic [31:0]      rd_data;
  logic             rxfe;
  logic             rxff;
  logic             rxfo;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  modport master (
    output pop, clear_ov,
    input  rd_data, rxfe, rxff, rxfo, rd_ptr, wr_ptr
  );

  modport slave (
    input  pop, clear_ov,
    output rd_data, rxfe, rxff, rxfo, rd_ptr, wr_ptr
  );
endinterface

// File: rtl/spi_rx_deserializer_fifo.sv
// Show-ahead RX FIFO with occupancy counter and sticky overflow flag.
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned PTR_W = PTR_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [31:0]      wdata_i,
  input  logic             pop_i,
  input  logic             clear_ov_i,
  output logic [31:0]      rd_data_o,
  output logic             rxfe_o,
  output logic             rxff_o,
  output logic             rxfo_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [PTR_W-1:0] wr_ptr_o
);

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             rxfo_q;
  logic             empty, full, do_push, do_pop, ovf_set;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  // A pop on a full FIFO frees the slot the concurrent push lands in.
  assign do_push = push_i & (~full | pop_i);
  assign do_pop  = pop_i & ~empty;
  assign ovf_set = push_i & full & ~pop_i;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      rxfo_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (ovf_set)         rxfo_q <= 1'b1;
      else if (clear_ov_i) rxfo_q <= 1'b0;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign rxfe_o    = empty;
  assign rxff_o    = full;
  assign rxfo_o    = rxfo_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign wr_ptr_o  = wr_ptr_q;

endmodule

// File: rtl/spi_rx_deserializer.sv
// SPI master receive deserializer: sync, edge detect, word FSM, RX FIFO.
// Optional SPI_RX_LOOPBACK_EN adds spi_tx_in/loopback to sample the TX line instead of MISO.
module spi_rx_deserializer
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned PTR_W = PTR_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic [4:0] word_size,
  input  logic       spi_clk_in,
  input  logic       frame_active,
  input  logic       spi_rx,
`ifdef SPI_RX_LOOPBACK_EN
  input  logic       spi_tx_in,
  input  logic       loopback,
`endif
  spi_rx_deserializer_if.slave bus
);

  logic        rx_src;
  logic [1:0]  rx_sync_q, clk_dly_q;
  logic        clk_prev_q;
  logic        rise, fall, sample_edge;
  state_e      state_q;
  logic [4:0]  bitcnt_q;
  logic [31:0] shreg_q, shreg_d;
  logic        push_q;
  logic [31:0] wdata_q;

`ifdef SPI_RX_LOOPBACK_EN
  assign rx_src = loopback ? spi_tx_in : spi_rx;
`else
  assign rx_src = spi_rx;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync_q  <= '0;
      clk_dly_q  <= '0;
      clk_prev_q <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], rx_src};
      clk_dly_q  <= {clk_dly_q[0], spi_clk_in};
      clk_prev_q <= clk_dly_q[1];
    end
  end

  assign rise        = clk_dly_q[1] & ~clk_prev_q;
  assign fall        = ~clk_dly_q[1] & clk_prev_q;
  assign sample_edge = (mode == MODE0 || mode == MODE3) ? rise : fall;
  assign shreg_d     = {shreg_q[30:0], rx_sync_q[1]};

  // The masked word is registered on the last sample edge so the FIFO write lands in the PUSH cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      push_q   <= 1'b0;
      wdata_q  <= '0;
    end else begin
      push_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          bitcnt_q <= word_size;
          if (enable && frame_active) state_q <= SHIFT;
        end
        SHIFT: begin
          if (!enable || !frame_active) begin
            state_q <= IDLE;
          end else if (sample_edge) begin
            shreg_q <= shreg_d;
            if (bitcnt_q == '0) begin
              state_q <= PUSH;
              push_q  <= 1'b1;
              wdata_q <= shreg_d & word_mask(word_size);
            end else begin
              bitcnt_q <= bitcnt_q - 5'd1;
            end
          end
        end
        PUSH: begin
          bitcnt_q <= word_size;
          state_q  <= (enable && frame_active) ? SHIFT : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  spi_rx_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push_q),
    .wdata_i    (wdata_q),
    .pop_i      (bus.pop),
    .clear_ov_i (bus.clear_ov),
    .rd_data_o  (bus.rd_data),
    .rxfe_o     (bus.rxfe),
    .rxff_o     (bus.rxff),
    .rxfo_o     (bus.rxfo),
    .rd_ptr_o   (bus.rd_ptr),
    .wr_ptr_o   (bus.wr_ptr)
  );

endmodule
